ecc_operand_seq: RTL and testbench
==================================

Name: ecc_operand_seq

Overview:
- Word-sequencer stage directly upstream of the ECC dual-port operand RAM. Drives one RAM port.
- Converts wide operand commands into word-serial RAM traffic:
  - a store writes NUM_WORDS consecutive words;
  - a load reads NUM_WORDS consecutive words and reassembles them into one wide operand.
- Lets the ECC arithmetic datapath move full field elements (e.g. 384-bit) with a single valid/ready handshake.

Parameters:
- ADDR_WIDTH, 10, RAM address width; must match the attached RAM.
- DATA_WIDTH, 32, RAM word width.
- NUM_WORDS, 12, words per operand; must be >= 2. Default gives 384 bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = store, 0 = load; sampled at accept.
- cmd_addr  in  ADDR_WIDTH  base word address; sampled at accept.
- wr_operand  in  NUM_WORDS*DATA_WIDTH  store data; sampled at accept. Word i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- rd_operand  out  NUM_WORDS*DATA_WIDTH  assembled load result, same word ordering.
- rd_valid  out  1  rd_operand complete.
- rd_ready  in  1  consumer accepts rd_operand.
- ram_en  out  1  RAM port enable; registered.
- ram_we  out  1  RAM write enable; registered.
- ram_addr  out  ADDR_WIDTH  RAM address; registered.
- ram_din  out  DATA_WIDTH  RAM write data; registered.
- ram_dout  in  DATA_WIDTH  RAM read data; valid one cycle after an enabled read.

Behaviour:
Clock and reset:
- Single clock domain: clk.
- rst is synchronous and active-high. When sampled high, the block goes to IDLE and clears: ram_en, ram_we, ram_addr, ram_din, rd_valid, rd_operand, and the word counter.
- cmd_ready is a decode of IDLE. It is 1 in the cycle after the reset edge.
- Commands presented while rst is high are ignored.
- Reset mid-operation aborts immediately. Any partial RAM write already issued stays in RAM; no further RAM access occurs.

State machine (IDLE, WRITE, READ, DRAIN, HOLD):
- IDLE: cmd_ready=1.
  - Accept = cmd_valid & cmd_ready at cycle T.
  - Latch cmd_addr; latch wr_operand if storing.
  - Go to WRITE if cmd_write=1, else READ.
- WRITE: cycles T+1..T+NUM_WORDS.
  - Outputs are ram_en=1, ram_we=1, ram_addr=base+i, ram_din=word i, for i=0..NUM_WORDS-1.
  - Afterwards return to IDLE; cmd_ready=1 in cycle T+NUM_WORDS+1.
- READ: cycles T+1..T+NUM_WORDS.
  - Outputs are ram_en=1, ram_we=0, ram_addr=base+i.
  - ram_dout for request i is captured into rd_operand word i at the end of cycle T+i+2.
- DRAIN: cycle T+NUM_WORDS+1. ram_en=0; capture the final word.
- HOLD: cycle T+NUM_WORDS+2 onward.
  - rd_valid=1; rd_operand stable.
  - On rd_valid & rd_ready, rd_valid=0 next cycle and the block returns to IDLE.
  - No new command is accepted while rd_valid=1.

RAM output rules:
- Outside the WRITE and READ issue cycles: ram_en=0 and ram_we=0.
- ram_addr and ram_din hold their last value.

Address arithmetic:
- base+i is computed modulo 2^ADDR_WIDTH; wrap-around is legal and silent.
- Example: base 1023, ADDR_WIDTH 10 → addresses 1023, 0, 1, …

Data rules:
- Word 0 (lowest address) is the least significant word.
- rd_operand words not yet captured hold their previous values until overwritten.
- After a completed load, rd_operand keeps its value until the next load's captures or reset.
- wr_operand changes after accept have no effect.

Throughput and latency:
- Store occupancy: NUM_WORDS+1 cycles, accept to accept.
- Load latency: NUM_WORDS+2 cycles, accept to rd_valid.

Test Plan:
1. Reset, then store: rst for 2 cycles → all outputs 0; cmd_ready=1 in the next cycle.
   - Store, base=0x010, words 0..11 = 0xA0000000+i.
   - → ram_we=1 for exactly 12 consecutive cycles at addresses 0x010..0x01B with the matching data.
   - → cmd_ready low for 12 cycles.
2. Load back: load base=0x010, with rd_ready held 1.
   - → rd_valid rises exactly 14 cycles after accept.
   - → rd_operand word i = 0xA0000000+i.
   - → rd_valid is high for exactly 1 cycle.
3. Backpressure: rd_ready=0 for 5 cycles after rd_valid.
   - → rd_valid and rd_operand stay stable; cmd_ready=0 throughout, and a concurrent cmd_valid is not accepted.
   - Release rd_ready → rd_valid drops next cycle; the pending command is accepted in the IDLE cycle after that.
4. Wrap: store then load at base=0x3FA (ADDR_WIDTH=10).
   - → addresses issued 0x3FA..0x3FF, 0x000..0x005.
   - → the data round-trips intact.
5. Reset mid-read: assert rst in the 4th READ cycle.
   - → next cycle ram_en=0, rd_valid=0, rd_operand=0, cmd_ready=1.
   - → a following store of 0x55555555 words completes normally.
6. Accept-time sampling: change wr_operand and cmd_addr one cycle after a store is accepted.
   - → RAM receives only the originally sampled address and data.

Source files
------------

// File: rtl/ecc_operand_seq.sv
// ecc_operand_seq
// Word sequencer in front of one port of the ECC operand RAM. A store command
// writes NUM_WORDS consecutive words starting at the base address. A load
// command reads NUM_WORDS consecutive words and reassembles them into one wide
// operand. Word 0 sits at the base address and is the least significant word.
// All RAM port outputs are registered, so the RAM sees clean signals.
module ecc_operand_seq #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] wr_operand,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] rd_operand,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic                            ram_en,
    output logic                            ram_we,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_din,
    input  logic [DATA_WIDTH-1:0]           ram_dout
);

    localparam int OP_WIDTH  = NUM_WORDS * DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(NUM_WORDS);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  nextIdx;
    logic                  ramEn_q, ramEn_d;
    logic                  ramWe_q, ramWe_d;
    logic [ADDR_WIDTH-1:0] ramAddr_q, ramAddr_d;
    logic [DATA_WIDTH-1:0] ramDin_q, ramDin_d;
    logic [OP_WIDTH-1:0]   wrData_q, wrData_d;
    logic                  capPend_q;
    logic [CNT_WIDTH-1:0]  capIdx_q;
    logic [OP_WIDTH-1:0]   rdOperand_q;

    // Next-state and next RAM-port values. The RAM outputs are computed one
    // cycle ahead, so the word shown in a WRITE/READ cycle was prepared in the
    // previous cycle (the accept cycle, for word 0).
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ramEn_d   = 1'b0;
        ramWe_d   = 1'b0;
        ramAddr_d = ramAddr_q;
        ramDin_d  = ramDin_q;
        wrData_d  = wrData_q;
        nextIdx   = idx_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    idx_d     = '0;
                    ramEn_d   = 1'b1;
                    ramAddr_d = cmd_addr;
                    if (cmd_write) begin
                        wrData_d = wr_operand;
                        ramWe_d  = 1'b1;
                        ramDin_d = wr_operand[DATA_WIDTH-1:0];
                        state_d  = WRITE;
                    end else begin
                        state_d  = READ;
                    end
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d     = nextIdx;
                    ramEn_d   = 1'b1;
                    ramWe_d   = 1'b1;
                    ramAddr_d = ramAddr_q + 1'b1;
                    ramDin_d  = wrData_q[int'(nextIdx) * DATA_WIDTH +: DATA_WIDTH];
                end
            end
            READ: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d     = nextIdx;
                    ramEn_d   = 1'b1;
                    ramAddr_d = ramAddr_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (rd_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, word counter and registered RAM-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ramEn_q   <= 1'b0;
            ramWe_q   <= 1'b0;
            ramAddr_q <= '0;
            ramDin_q  <= '0;
            wrData_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ramEn_q   <= ramEn_d;
            ramWe_q   <= ramWe_d;
            ramAddr_q <= ramAddr_d;
            ramDin_q  <= ramDin_d;
            wrData_q  <= wrData_d;
        end
    end

    // Read data returns one cycle after its request; remember which word was
    // requested so it can be dropped into the right slot when it returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            capPend_q <= 1'b0;
            capIdx_q  <= '0;
        end else begin
            capPend_q <= (state_q == READ);
            capIdx_q  <= idx_q;
        end
    end

    // Assemble the load result. Words not yet captured keep their old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdOperand_q <= '0;
        end else if (capPend_q) begin
            rdOperand_q[int'(capIdx_q) * DATA_WIDTH +: DATA_WIDTH] <= ram_dout;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rd_valid   = (state_q == HOLD);
    assign rd_operand = rdOperand_q;
    assign ram_en     = ramEn_q;
    assign ram_we     = ramWe_q;
    assign ram_addr   = ramAddr_q;
    assign ram_din    = ramDin_q;

endmodule

// File: tb/tb_ecc_operand_seq.sv
// tb_ecc_operand_seq
// Scoreboard bench for ecc_operand_seq. The driver issues commands and pushes
// the RAM traffic and load results it expects into queues. A monitor on the
// falling edge pops and compares them as the DUT produces them. A simple RAM
// model sits on the DUT's RAM port.
module tb_ecc_operand_seq;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int NW    = 12;
    localparam int OPW   = NW * DW;
    localparam int NEVER = 1000000000;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } ramTxn_t;

    typedef struct {
        int             cyc;
        logic [OPW-1:0] data;
    } rdTxn_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_write = 1'b0;
    logic [AW-1:0]  cmd_addr = '0;
    logic [OPW-1:0] wr_operand = '0;
    logic [OPW-1:0] rd_operand;
    logic           rd_valid;
    logic           rd_ready = 1'b1;
    logic           ram_en;
    logic           ram_we;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_din;
    logic [DW-1:0]  ram_dout;

    int             cyc = 0;
    int             checks = 0;
    int             errors = 0;
    int             expReadyFrom = 0;
    bit             seenValid = 0;
    bit             loadInFlight = 0;
    bit             randDone = 0;
    logic [OPW-1:0] lastOperand = '0;
    ramTxn_t        ramQ[$];
    rdTxn_t         rdQ[$];
    logic [DW-1:0]  refMem [0:(1<<AW)-1];
    logic [DW-1:0]  mem [0:(1<<AW)-1];
    logic           memInit = 1'b0;

    ecc_operand_seq #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_WORDS (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .wr_operand(wr_operand),
        .rd_operand(rd_operand),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Cycle number; stable between edges for both driver and monitor.
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM model with one cycle of read latency; zero-filled on the first edge.
    always @(posedge clk) begin
        if (!memInit) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            memInit <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [OPW-1:0] actual,
                               input logic [OPW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [OPW-1:0] randOperand();
        logic [OPW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*DW +: DW] = $urandom();
        return r;
    endfunction

    // Issue one command, wait (bounded) for acceptance, then scramble the
    // command inputs and record what the RAM and the consumer should see.
    task automatic applyStimulus(input logic write, input logic [AW-1:0] addr,
                                 input logic [OPW-1:0] op);
        int             waitCnt = 0;
        bit             accepted = 0;
        int             acceptCyc = 0;
        logic [AW-1:0]  a;
        logic [OPW-1:0] expOp;
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_write  = write;
        cmd_addr   = addr;
        wr_operand = op;
        while (!accepted && waitCnt < 300) begin
            if (cmd_ready === 1'b1) begin
                accepted  = 1;
                acceptCyc = cyc;
            end
            @(posedge clk); #1;
            waitCnt++;
        end
        cmd_valid  = 1'b0;
        cmd_write  = 1'($urandom_range(0, 1));
        cmd_addr   = AW'($urandom());
        wr_operand = randOperand();
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: command not accepted within 300 cycles");
        end else if (write) begin
            for (int i = 0; i < NW; i++) begin
                a = addr + AW'(i);
                refMem[a] = op[i*DW +: DW];
                ramQ.push_back('{acceptCyc + 1 + i, 1'b1, a, op[i*DW +: DW]});
            end
            expReadyFrom = acceptCyc + NW + 1;
        end else begin
            for (int i = 0; i < NW; i++) begin
                a = addr + AW'(i);
                expOp[i*DW +: DW] = refMem[a];
                ramQ.push_back('{acceptCyc + 1 + i, 1'b0, a, '0});
            end
            rdQ.push_back('{acceptCyc + NW + 2, expOp});
            loadInFlight = 1;
            expReadyFrom = NEVER;
        end
    endtask

    // Pulse reset for n cycles, clear the expectations and check reset values.
    task automatic resetDut(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        ramQ.delete();
        rdQ.delete();
        seenValid    = 0;
        loadInFlight = 0;
        lastOperand  = '0;
        expReadyFrom = cyc;
        checkOutput("rst_ram_en", ram_en, 1'b0);
        checkOutput("rst_ram_we", ram_we, 1'b0);
        checkOutput("rst_ram_addr", ram_addr, '0);
        checkOutput("rst_ram_din", ram_din, '0);
        checkOutput("rst_rd_valid", rd_valid, 1'b0);
        checkOutput("rst_rd_operand", rd_operand, '0);
        checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
    endtask

    task automatic waitIdle(input int bound);
        int w = 0;
        while (!(ramQ.size() == 0 && rdQ.size() == 0 && cmd_ready === 1'b1) && w < bound) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (w >= bound) begin
            errors++;
            $display("[TB] FAIL idle_timeout: %0d RAM and %0d load items outstanding",
                     ramQ.size(), rdQ.size());
        end
    endtask

    // Monitor: compare RAM traffic, cmd_ready and load results every cycle.
    always @(negedge clk) begin
        ramTxn_t e;
        if (rst === 1'b0) begin
            if (ramQ.size() > 0 && ramQ[0].cyc == cyc) begin
                e = ramQ.pop_front();
                checkOutput("ram_en", ram_en, 1'b1);
                checkOutput("ram_we", ram_we, e.we);
                checkOutput("ram_addr", ram_addr, e.addr);
                if (e.we) checkOutput("ram_din", ram_din, e.din);
            end else begin
                checkOutput("ram_en_idle", ram_en, 1'b0);
                checkOutput("ram_we_idle", ram_we, 1'b0);
            end
            checkOutput("cmd_ready", cmd_ready, cyc >= expReadyFrom);
            if (!loadInFlight) checkOutput("rd_operand_keep", rd_operand, lastOperand);
            if (rd_valid === 1'b1) begin
                if (rdQ.size() == 0) begin
                    checkOutput("rd_valid_spurious", rd_valid, 1'b0);
                end else begin
                    if (!seenValid) begin
                        checkOutput("rd_latency", cyc, rdQ[0].cyc);
                        seenValid = 1;
                    end
                    checkOutput("rd_operand", rd_operand, rdQ[0].data);
                    if (rd_ready) begin
                        lastOperand  = rdQ[0].data;
                        void'(rdQ.pop_front());
                        seenValid    = 0;
                        loadInFlight = 0;
                        expReadyFrom = cyc + 1;
                    end
                end
            end else if (seenValid) begin
                checkOutput("rd_valid_hold", rd_valid, 1'b1);
            end else if (rdQ.size() > 0 && cyc >= rdQ[0].cyc) begin
                checkOutput("rd_valid_rise", rd_valid, 1'b1);
                seenValid = 1;
            end
        end
    end

    initial begin
        logic [OPW-1:0] op;
        for (int i = 0; i < (1 << AW); i++) refMem[i] = '0;

        // Reset, then store A0000000+i at 0x010
        resetDut(2);
        for (int i = 0; i < NW; i++) op[i*DW +: DW] = 32'hA0000000 + DW'(i);
        applyStimulus(1'b1, 10'h010, op);
        waitIdle(100);

        // Load back with rd_ready held high
        rd_ready = 1'b1;
        applyStimulus(1'b0, 10'h010, '0);
        waitIdle(100);

        // Backpressure: consumer stalls 5 cycles while a store is pending
        rd_ready = 1'b0;
        applyStimulus(1'b0, 10'h010, '0);
        fork
            begin : stallBranch
                int w;
                w = 0;
                while (rd_valid !== 1'b1 && w < 50) begin
                    @(posedge clk); #1;
                    w++;
                end
                repeat (5) begin
                    @(posedge clk); #1;
                end
                rd_ready = 1'b1;
            end
            applyStimulus(1'b1, 10'h100, randOperand());
        join
        waitIdle(100);

        // Address wrap at the top of the RAM
        applyStimulus(1'b1, 10'h3FA, randOperand());
        applyStimulus(1'b0, 10'h3FA, '0);
        waitIdle(100);

        // Reset in the 4th READ cycle, then a normal store and load
        applyStimulus(1'b0, 10'h3FA, '0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        resetDut(1);
        applyStimulus(1'b1, 10'h020, {NW{32'h55555555}});
        applyStimulus(1'b0, 10'h020, '0);
        waitIdle(100);

        // Random commands with a randomly stalling consumer
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    applyStimulus(1'($urandom_range(0, 1)), AW'($urandom()), randOperand());
                end
                waitIdle(400);
                randDone = 1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk); #1;
                    rd_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rd_ready = 1'b1;
        waitIdle(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
